// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline.
// This block watches the ID, EX and MEM stages. It resolves three cases:
// load-use hazards, taken-branch flushes, and multi-cycle data-memory waits.
// A data-memory wait that runs too long latches a sticky timeout and
// moves the block to ERR. Only rst leaves ERR.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   id_rs, id_rt         source fields of the instruction in ID
//   id_uses_rt           the ID instruction reads rt
//   idex_mem_read        the EX instruction is a load
//   idex_rt              destination of the EX instruction
//   ex_branch_taken      the branch in EX resolved taken
//   mem_req, mem_ready   data-memory access in MEM, and its completion
//   pc_write, ifid_write, exmem_write          stage load enables
//   ifid_flush, idex_flush, memwb_bubble       NOP/bubble injection
//   mem_timeout          sticky data-memory timeout flag
//   state                FSM state (0 RUN, 1 MEM_WAIT, 2 ERR)
//   stall_cnt, flush_cnt saturating performance counters
module pipe_hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             idex_mem_read,
    input  logic [4:0]       idex_rt,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_write,
    output logic             memwb_bubble,
    output logic             mem_timeout,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

    state_t     cur, nxt;
    logic [7:0] wcnt, wcnt_nxt;
    logic       timeout_set;
    logic       branch_flush;
    logic       memstall, lu;

    assign memstall = mem_req & ~mem_ready;
    assign lu = idex_mem_read & (idex_rt != 5'd0) &
                ((idex_rt == id_rs) | (id_uses_rt & (idex_rt == id_rt)));

    assign state = cur;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur         <= RUN;
            wcnt        <= 8'd0;
            mem_timeout <= 1'b0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
        end else begin
            cur  <= nxt;
            wcnt <= wcnt_nxt;
            if (timeout_set)
                mem_timeout <= 1'b1;
            if (!pc_write && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (branch_flush && flush_cnt != '1)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

    always_comb begin
        nxt          = cur;
        wcnt_nxt     = wcnt;
        timeout_set  = 1'b0;
        branch_flush = 1'b0;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        exmem_write  = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        memwb_bubble = 1'b0;
        // While in reset, keep the plain RUN enables so that no
        // reset-time input can look like a stall.
        if (!rst) begin
            case (cur)
                RUN: begin
                    // A pending memory stall has priority. A branch or
                    // load-use in the same cycle is re-evaluated after the freeze.
                    if (memstall) begin
                        pc_write     = 1'b0;
                        ifid_write   = 1'b0;
                        exmem_write  = 1'b0;
                        memwb_bubble = 1'b1;
                        nxt          = MEM_WAIT;
                        wcnt_nxt     = 8'd1;
                    end else if (ex_branch_taken) begin
                        ifid_flush   = 1'b1;
                        idex_flush   = 1'b1;
                        branch_flush = 1'b1;
                    end else if (lu) begin
                        // One bubble suffices: the load leaves EX next cycle.
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_flush = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    // ID/EX is not flushed here, so a taken branch in EX
                    // survives the freeze and is handled once RUN resumes.
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    exmem_write  = 1'b0;
                    memwb_bubble = 1'b1;
                    if (mem_ready) begin
                        nxt      = RUN;
                        wcnt_nxt = 8'd0;
                    end else if (wcnt == TO_LIM) begin
                        nxt         = ERR;
                        timeout_set = 1'b1;
                    end else begin
                        wcnt_nxt = wcnt + 8'd1;
                    end
                end
                ERR: begin
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    exmem_write  = 1'b0;
                    ifid_flush   = 1'b1;
                    idex_flush   = 1'b1;
                    memwb_bubble = 1'b1;
                end
                default: nxt = RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. Expected values are hand-computed.
// The bench builds the DUT with TIMEOUT=4 and CNT_W=4, so counter
// saturation (at 15) can be reached in a short run.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, idex_rt;
    logic       id_uses_rt, idex_mem_read, ex_branch_taken, mem_req, mem_ready;
    logic       pc_write, ifid_write, ifid_flush, idex_flush, exmem_write;
    logic       memwb_bubble, mem_timeout;
    logic [1:0] state;
    logic [3:0] stall_cnt, flush_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
        .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .exmem_write(exmem_write),
        .memwb_bubble(memwb_bubble), .mem_timeout(mem_timeout),
        .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the posedge. The checks run 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
        idex_mem_read = 1'b0; idex_rt = 5'd0; ex_branch_taken = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        idle();
        // Reset: hold reset for 2 cycles while MEM reports an unfinished access.
        rst = 1'b1; mem_req = 1'b1; mem_ready = 1'b0;
        step(); step();
        check("rst_state", state, 0);
        check("rst_pc_write", pc_write, 1);
        check("rst_stall", stall_cnt, 0);
        check("rst_flush", flush_cnt, 0);
        check("rst_timeout", mem_timeout, 0);
        rst = 1'b0; #1;
        check("rel_freeze_pc", pc_write, 0);
        check("rel_freeze_bub", memwb_bubble, 1);
        step();
        check("rel_state", state, 1);
        check("rel_stall", stall_cnt, 1);

        // Load-use hazard through rs, then the same case with rt=0.
        do_reset();
        idex_mem_read = 1'b1; idex_rt = 5'd5; id_rs = 5'd5; #1;
        check("lu_pc", pc_write, 0);
        check("lu_ifid", ifid_write, 0);
        check("lu_idex_flush", idex_flush, 1);
        check("lu_exmem", exmem_write, 1);
        step();
        check("lu_stall", stall_cnt, 1);
        check("lu_state", state, 0);
        idex_rt = 5'd0; id_rs = 5'd0; #1;
        check("lu0_pc", pc_write, 1);
        check("lu0_idex_flush", idex_flush, 0);
        step();
        check("lu0_stall", stall_cnt, 1);
        // Load-use through rt depends on id_uses_rt.
        idex_rt = 5'd7; id_rs = 5'd3; id_rt = 5'd7; id_uses_rt = 1'b1; #1;
        check("lurt_pc", pc_write, 0);
        id_uses_rt = 1'b0; #1;
        check("lurt_nouse_pc", pc_write, 1);
        step();
        check("lurt_stall", stall_cnt, 1);

        // A branch in the same cycle as a load-use: the branch wins.
        do_reset();
        idex_mem_read = 1'b1; idex_rt = 5'd5; id_rs = 5'd5; ex_branch_taken = 1'b1; #1;
        check("br_ifid_flush", ifid_flush, 1);
        check("br_idex_flush", idex_flush, 1);
        check("br_pc", pc_write, 1);
        step();
        check("br_flush_cnt", flush_cnt, 1);
        check("br_stall_cnt", stall_cnt, 0);

        // Memory wait: ready is low for 3 cycles, then high.
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0; #1;
        check("mw_pc0", pc_write, 0);
        check("mw_exmem0", exmem_write, 0);
        step();
        check("mw_state1", state, 1);
        step(); step();
        check("mw_state3", state, 1);
        mem_ready = 1'b1; #1;
        check("mw_rdy_pc", pc_write, 0);
        check("mw_rdy_bub", memwb_bubble, 1);
        step();
        check("mw_back_state", state, 0);
        check("mw_stall", stall_cnt, 4);
        mem_req = 1'b0; mem_ready = 1'b0; #1;
        check("mw_resume_pc", pc_write, 1);

        // Timeout (TIMEOUT=4): ready never arrives.
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        repeat (4) step();
        check("to_state_pre", state, 1);
        check("to_flag_pre", mem_timeout, 0);
        step();
        check("to_state", state, 2);
        check("to_flag", mem_timeout, 1);
        check("to_stall5", stall_cnt, 5);
        idle(); mem_ready = 1'b1; #1;
        check("err_pc", pc_write, 0);
        check("err_exmem", exmem_write, 0);
        check("err_ifid_flush", ifid_flush, 1);
        check("err_idex_flush", idex_flush, 1);
        check("err_bub", memwb_bubble, 1);
        repeat (10) step();
        check("err_hold", state, 2);
        check("err_stall15", stall_cnt, 15);
        step();
        check("stall_sat", stall_cnt, 15);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("err_rst_state", state, 0);
        check("err_rst_flag", mem_timeout, 0);
        check("err_rst_stall", stall_cnt, 0);

        // Memory stall and branch in the same cycle: only the freeze applies.
        // The branch is handled after the freeze ends.
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0; ex_branch_taken = 1'b1; #1;
        check("mb_ifid_flush", ifid_flush, 0);
        check("mb_pc", pc_write, 0);
        step();
        check("mb_state", state, 1);
        check("mb_flush0", flush_cnt, 0);
        mem_ready = 1'b1; #1;
        check("mb_rdy_flush", ifid_flush, 0);
        step();
        check("mb_state_run", state, 0);
        check("mb_flush_still0", flush_cnt, 0);
        mem_req = 1'b0; mem_ready = 1'b0; #1;
        check("mb_br_flush", ifid_flush, 1);
        check("mb_br_pc", pc_write, 1);
        step();
        check("mb_flush1", flush_cnt, 1);
        // Hold the branch until flush_cnt saturates.
        repeat (20) step();
        check("flush_sat", flush_cnt, 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipelined CPU. It watches the ID, EX and MEM stages and drives the write-enable, flush and bubble controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards, branch flushes and multi-cycle data-memory waits, and detects memory timeouts. It keeps saturating stall and flush performance counters.

Parameters:
TIMEOUT, 16, MEM_WAIT cycles (1..255) before a timeout is declared
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  system clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
id_rs  in  5  rs field of the instruction in ID
id_rt  in  5  rt field of the instruction in ID
id_uses_rt  in  1  instruction in ID reads rt as a source
idex_mem_read  in  1  instruction in EX is a load
idex_rt  in  5  destination rt of the instruction in EX
ex_branch_taken  in  1  branch in EX resolved taken
mem_req  in  1  instruction in MEM accesses data memory
mem_ready  in  1  data memory completes the access this cycle
pc_write  out  1  PC update enable
ifid_write  out  1  IF/ID load enable
ifid_flush  out  1  IF/ID clear to NOP
idex_flush  out  1  ID/EX clear to NOP (control bits zeroed)
exmem_write  out  1  EX/MEM load enable
memwb_bubble  out  1  MEM/WB loads Reg_w=0, Mem_to_reg=0
mem_timeout  out  1  sticky error flag
state  out  2  FSM state (RUN=0, MEM_WAIT=1, ERR=2)
stall_cnt  out  CNT_W  cycles with pc_write=0
flush_cnt  out  CNT_W  taken-branch flushes

Behaviour:
- Registered: FSM state, wait counter wcnt[7:0], mem_timeout, stall_cnt, flush_cnt. Control outputs are combinational from the current state and inputs.
- Reset (rst=1 at posedge): state=RUN, wcnt=0, mem_timeout=0, both counters=0. While rst=1, outputs take the RUN decode. Reset overrides all states, including mid-wait and ERR.
- Condition terms:
  - memstall = mem_req & ~mem_ready.
  - lu = idex_mem_read & (idex_rt!=0) & (idex_rt==id_rs | (id_uses_rt & idex_rt==id_rt)).
- Default RUN outputs: pc_write=1, ifid_write=1, exmem_write=1, all flush/bubble=0.
- RUN decode, first matching condition wins:
  - 1. memstall: pc_write=0, ifid_write=0, exmem_write=0, memwb_bubble=1. Next state MEM_WAIT, wcnt<=1. Any branch or load-use is ignored this cycle and re-evaluated after the freeze.
  - 2. ex_branch_taken: ifid_flush=1, idex_flush=1, pc_write=1. flush_cnt increments.
  - 3. lu: pc_write=0, ifid_write=0, idex_flush=1. Exactly one bubble per hazard, because next cycle the load has left EX.
- MEM_WAIT: same freeze outputs as RUN case 1.
  - mem_ready=1: next state RUN, wcnt<=0. The freeze outputs still apply this cycle; EX/MEM, IF/ID and PC resume next cycle.
  - mem_ready=0 and wcnt==TIMEOUT: next state ERR, mem_timeout<=1.
  - Otherwise wcnt<=wcnt+1.
  - mem_req is not re-sampled in MEM_WAIT.
- ERR: pc_write=0, ifid_write=0, exmem_write=0, ifid_flush=1, idex_flush=1, memwb_bubble=1. ERR is left only by rst.
- stall_cnt increments on every cycle with pc_write=0 and rst=0, in every state. flush_cnt increments only in RUN case 2.
- Both counters saturate at all-ones and do not wrap.
- A branch waiting in EX during a freeze is held, because ID/EX is not flushed in MEM_WAIT. It is acted on in the first RUN cycle after the freeze.

Test Plan:
- Reset: hold rst 2 cycles with mem_req=1, mem_ready=0 → state=0, pc_write=1, counters=0, mem_timeout=0. First cycle after release → freeze outputs, then state=1.
- Load-use: idex_mem_read=1, idex_rt=5, id_rs=5 for one cycle → pc_write=0, ifid_write=0, idex_flush=1, stall_cnt=1. Repeat with idex_rt=0 → no stall.
- Branch vs load-use in the same cycle: ex_branch_taken=1 and lu=1 → ifid_flush=1, idex_flush=1, pc_write=1, flush_cnt=1, stall_cnt unchanged.
- Memory wait: mem_req=1, mem_ready low 3 cycles then high → freeze outputs for 4 cycles, state back to 0, stall_cnt=4.
- Timeout at TIMEOUT=4: mem_ready never asserted → state=2 and mem_timeout=1 after 5 cycles. ERR holds 10 further cycles; rst returns state to 0.
- Simultaneous memstall + ex_branch_taken: freeze only, flush_cnt=0. When mem_ready=1 the branch flush occurs on the next RUN cycle and flush_cnt=1.
